// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider and the execute stage that drives it.
// The execute stage builds its stall request from these same constants.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int DIV_CYCLES = 32;

  // Execute-stage opcodes that route to this unit.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement magnitude when the operand is treated as signed and is negative.
  function automatic logic [DIV_CYCLES-1:0] div_magnitude(input logic is_signed,
                                                          input logic [DIV_CYCLES-1:0] value);
    if (is_signed && value[DIV_CYCLES-1]) begin
      div_magnitude = -value;
    end else begin
      div_magnitude = value;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {partial remainder, dividend} working register.
// Purely combinational; the sequencing lives in div_seq.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]  work_i,
  input  logic [DATA_W-1:0]  divisor_i,
  output logic [2*DATA_W:0]  work_o
);

  logic [2*DATA_W:0] shifted;
  logic [DATA_W:0]   diff;

  always_comb begin
    shifted = work_i << 1;
    diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_i};
    // NOTE: work_o is assigned before the if so every path drives it and no latch is inferred.
    work_o  = shifted;
    if (!diff[DATA_W]) begin
      work_o = {diff, shifted[DATA_W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit: latches magnitudes, runs DATA_W restoring steps,
// then fixes signs and holds {remainder, quotient} until the execute stage releases it.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W:0]   work_q;
  logic [2*DATA_W:0]   step_d;
  logic [DATA_W-1:0]   divisor_q;
  logic                neg_quot_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W-1:0]   op1_mag_d;
  logic [DATA_W-1:0]   op2_mag_d;
  logic [DATA_W-1:0]   quot_d;
  logic [DATA_W-1:0]   rem_d;

  div_step #(.DATA_W(DATA_W)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_d)
  );

  always_comb begin
    op1_mag_d = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag_d = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quot_d    = neg_quot_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_d     = neg_rem_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
  end

  // NOTE: every register here uses <= so all of them sample pre-edge values in the same step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              cnt_q      <= '0;
              work_q     <= {{(DATA_W+1){1'b0}}, op1_mag_d};
              divisor_q  <= op2_mag_d;
              neg_quot_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_q  <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end

        DivByZero: begin
          state_q  <= DivEnd;
          result_q <= '0;
          ready_q  <= DivResultReady;
        end

        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            work_q <= step_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= {rem_d, quot_d};
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
            cnt_q    <= '0;
          end
        end

        DivEnd: begin
          // The result is held until the execute stage drops its request.
          if (start_i == DivStop || annul_i) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end

        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != DivFree);

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit integer divider with its own sequencing FSM, owned by the execute stage for DIV/DIVU.
- The execute stage raises start_i with operands and stalls the pipeline until ready_o.
- It then writes result_o {remainder, quotient} to HI/LO.
- The execute stage can cancel an in-flight division with annul_i, for flush or exception.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start.
- opdata1_i  in  DATA_W  dividend; sampled with start.
- opdata2_i  in  DATA_W  divisor; sampled with start.
- start_i  in  1  request; level held by the execute stage until ready_o is seen.
- annul_i  in  1  cancel; overrides start_i.
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  result valid; registered.
- busy_o  out  1  state != IDLE; combinational from the state register.

Behaviour:
- Reset (sync, rst=1):
  - State goes to IDLE; cnt=0; working registers are cleared.
  - result_o=0 and ready_o=0.
  - Reset overrides every state, including mid-division; no partial result ever appears.
- States: IDLE, BYZERO, ON, END, encoded 2'b00..2'b11 in the package.
- IDLE:
  - start_i=1 and annul_i=0 at the edge ending cycle t:
    - opdata2_i==0 -> BYZERO.
    - Otherwise -> ON, cnt=0, operands latched.
  - On the latch in the signed case, each negative operand is replaced by its two's-complement magnitude, and the sign flags are stored.
  - In IDLE, ready_o=0 and result_o=0.
- BYZERO:
  - Lasts one cycle, then -> END with result_o=0 and ready_o=1, visible in cycle t+2.
  - No exception is raised; MIPS leaves the result undefined, and 0 is the team choice.
- ON (restoring division):
  - Working register is 65 bits: {partial remainder, dividend}.
  - Each edge while cnt<32: shift left 1; subtract the divisor from the upper 33 bits; if the difference is non-negative, keep it and set bit0=1, else keep the shifted value with bit0=0; cnt++.
  - At the edge with cnt==32 (finalize):
    - Signed case: negate the quotient if the sign flags differ; negate the remainder if the dividend was negative.
    - Register result_o, set ready_o=1, -> END.
  - Latency: ready_o is high in cycle t+34 (32 iterations + 1 finalize + 1 start).
  - annul_i=1 during ON: at that edge -> IDLE, cnt=0, ready_o stays 0, and no result is produced.
- END:
  - result_o and ready_o hold while start_i=1.
  - start_i=0: next edge -> IDLE, ready_o=0, result_o=0.
  - annul_i=1: -> IDLE at that edge, same as start_i=0.
  - A back-to-back new start requires a return through IDLE, i.e. start_i must drop for at least one cycle.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0 (wraps; no trap).
  - Divisor > dividend -> quotient 0, remainder = dividend.
  - start_i during ON or BYZERO is ignored. Operand changes after the latch have no effect.
- Width rules:
  - Magnitudes are DATA_W-bit unsigned; 0x80000000 stays representable as a magnitude.
  - The subtraction is DATA_W+1 bits wide; its sign bit selects the outcome.

Decomposition:
- Shared defines/package:
  - State encodings DivFree/DivByZero/DivOn/DivEnd.
  - DivStart/DivStop.
  - DivResultReady/DivResultNotReady.
  - DIV_CYCLES=32.
  - These sit alongside the existing EXE_* opcodes; the execute stage also uses them to build stallreq.
- Sub-module div_step:
  - Combinational single iteration.
  - In: 65-bit working register and the divisor. Out: next working register.
  - Instantiated once; the sequencing stays in div_seq.

Test Plan:
- Unsigned: 100 / 7, start at cycle t -> ready_o=1 at exactly t+34, result_o={32'd2, 32'd14}; drop start -> ready_o=0 next cycle.
- Signed: -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x1.
- Divide by zero: 1234 / 0 -> ready_o at t+2, result_o=0. Also 0x80000000 / 0xFFFFFFFF signed -> {0, 0x80000000}.
- Annul: annul_i pulsed in the 10th ON cycle -> busy_o=0 next cycle and ready_o never rises. A new start of 9 / 3 next cycle -> {0, 3} at +34.
- Reset mid-op: rst=1 during ON cycle 20 -> next cycle IDLE, result_o=0, ready_o=0. A following 0xFFFFFFFF / 0x10 unsigned -> {0xF, 0x0FFFFFFF}.
- Hold in END: start_i held high for 5 cycles after ready -> result_o stable and ready_o=1 throughout; start_i ignored while in ON (changing operands mid-op has no effect).
